// File: rtl/game_timing_pkg.sv
// Shared timing helpers for the game tick path: period tables, index widths
// and the per-cycle decode of the tick generator's control inputs.
package game_timing_pkg;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_PAUSE,
        MODE_STEP,
        MODE_RESTART
    } tick_mode_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A select or index bus is never narrower than one bit, even for one entry.
    function automatic int index_width(input int entries);
        return (clog2(entries) < 1) ? 1 : clog2(entries);
    endfunction

    function automatic int level_width(input int num_levels);
        return index_width(num_levels);
    endfunction

    function automatic int tick_period(input int clk_freq, input int base_freq,
                                       input int step_freq, input int level);
        return clk_freq / (base_freq + level * step_freq);
    endfunction

    function automatic int sub_period(input int clk_freq, input int base_freq,
                                      input int step_freq, input int level,
                                      input int subdiv);
        return tick_period(clk_freq, base_freq, step_freq, level) / subdiv;
    endfunction

endpackage

// File: rtl/tick_subdivider.sv
// Splits each main tick period into SUBDIV animation sub-intervals of subp
// cycles; any leftover cycles simply lengthen the last sub-interval.
module tick_subdivider
    import game_timing_pkg::*;
#(
    parameter int SUBDIV = 4,
    parameter int SUBP_W = 16,
    localparam int IDX_W = index_width(SUBDIV)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              enable,
    input  logic [SUBP_W-1:0] subp,
    input  logic              main_tick,
    output logic              sub_tick,
    output logic [IDX_W-1:0]  sub_idx
);

    logic [SUBP_W-1:0] sub_cnt_q, sub_cnt_d;
    logic [IDX_W-1:0]  sub_idx_q, sub_idx_d;
    logic              sub_tick_q, sub_tick_d;
    logic              last_interval;
    logic              interval_end;

    always_comb begin
        sub_cnt_d     = sub_cnt_q;
        sub_idx_d     = sub_idx_q;
        sub_tick_d    = 1'b0;
        last_interval = (int'(sub_idx_q) >= SUBDIV - 1);
        interval_end  = (sub_cnt_q == subp - SUBP_W'(1));

        if (clear) begin
            sub_cnt_d = '0;
            sub_idx_d = '0;
        end else if (main_tick) begin
            sub_tick_d = 1'b1;
            sub_cnt_d  = '0;
            sub_idx_d  = '0;
        end else if (enable) begin
            if (interval_end) begin
                sub_cnt_d = '0;
                // The final interval keeps running silently until the main tick.
                if (!last_interval) begin
                    sub_tick_d = 1'b1;
                    sub_idx_d  = sub_idx_q + IDX_W'(1);
                end
            end else begin
                sub_cnt_d = sub_cnt_q + SUBP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sub_cnt_q  <= '0;
            sub_idx_q  <= '0;
            sub_tick_q <= 1'b0;
        end else begin
            sub_cnt_q  <= sub_cnt_d;
            sub_idx_q  <= sub_idx_d;
            sub_tick_q <= sub_tick_d;
        end
    end

    assign sub_tick = sub_tick_q;
    assign sub_idx  = sub_idx_q;

endmodule

// File: rtl/speed_tick_gen.sv
// Programmable-rate game tick generator with pause, single-step, restart and
// an animation sub-tick; level changes only take effect at a period boundary.
module speed_tick_gen
    import game_timing_pkg::*;
#(
    parameter int INPUT_CLK_FREQ  = 50_000_000,
    parameter int BASE_TICK_FREQ  = 2,
    parameter int LEVEL_STEP_FREQ = 1,
    parameter int NUM_LEVELS      = 8,
    parameter int SUBDIV          = 4,
    parameter int CNT_W           = 16,
    localparam int LVL_W          = level_width(NUM_LEVELS),
    localparam int SIDX_W         = index_width(SUBDIV)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [LVL_W-1:0]  level_i,
    input  logic              pause_i,
    input  logic              step_i,
    input  logic              restart_i,
    output logic              tick,
    output logic              sub_tick,
    output logic [SIDX_W-1:0] sub_idx,
    output logic [LVL_W-1:0]  active_level,
    output logic [CNT_W-1:0]  tick_count
);

    localparam int PER0  = tick_period(INPUT_CLK_FREQ, BASE_TICK_FREQ, LEVEL_STEP_FREQ, 0);
    localparam int CTR_W = (clog2(PER0) < 1) ? 1 : clog2(PER0);
    localparam int TAB_N = 1 << LVL_W;

    // Tables are padded to the full select range so every level_i code has an entry.
    logic [CTR_W-1:0] last_cnt_tab [TAB_N];
    logic [CTR_W-1:0] subp_tab     [TAB_N];

    if (LEVEL_STEP_FREQ < 0 || SUBDIV < 1) begin : g_bad_params
        $fatal(1, "speed_tick_gen: LEVEL_STEP_FREQ must be >= 0 and SUBDIV >= 1");
    end

    for (genvar g = 0; g < TAB_N; g++) begin : g_tab
        localparam int LVL = (g < NUM_LEVELS) ? g : NUM_LEVELS - 1;
        localparam int PER = tick_period(INPUT_CLK_FREQ, BASE_TICK_FREQ, LEVEL_STEP_FREQ, LVL);
        localparam int SUBP = sub_period(INPUT_CLK_FREQ, BASE_TICK_FREQ, LEVEL_STEP_FREQ,
                                         LVL, SUBDIV);
        if (PER < 2 || SUBP < 1) begin : g_bad_period
            $fatal(1, "speed_tick_gen: level %0d period %0d too short", LVL, PER);
        end
        assign last_cnt_tab[g] = CTR_W'(PER - 1);
        assign subp_tab[g]     = CTR_W'(SUBP);
    end

    logic [CTR_W-1:0] counter_q, counter_d;
    logic [LVL_W-1:0] active_level_q, active_level_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] tick_count_q, tick_count_d;
    logic [LVL_W-1:0] level_clamped;
    logic             period_end;
    logic             sub_clear;
    logic             sub_enable;
    tick_mode_e       mode;

    always_comb begin
        counter_d      = counter_q;
        active_level_d = active_level_q;
        tick_d         = 1'b0;
        tick_count_d   = tick_count_q;
        sub_clear      = 1'b0;
        sub_enable     = 1'b0;
        level_clamped  = (int'(level_i) >= NUM_LEVELS) ? LVL_W'(NUM_LEVELS - 1) : level_i;
        period_end     = (counter_q == last_cnt_tab[active_level_q]);

        if (restart_i) begin
            mode = MODE_RESTART;
        end else if (pause_i) begin
            mode = step_i ? MODE_STEP : MODE_PAUSE;
        end else begin
            mode = MODE_RUN;
        end

        case (mode)
            MODE_RESTART: begin
                counter_d      = '0;
                active_level_d = level_clamped;
                sub_clear      = 1'b1;
            end
            MODE_STEP: begin
                counter_d      = '0;
                active_level_d = level_clamped;
                tick_d         = 1'b1;
                tick_count_d   = tick_count_q + CNT_W'(1);
            end
            MODE_RUN: begin
                sub_enable = 1'b1;
                if (period_end) begin
                    counter_d      = '0;
                    active_level_d = level_clamped;
                    tick_d         = 1'b1;
                    tick_count_d   = tick_count_q + CNT_W'(1);
                end else begin
                    counter_d = counter_q + CTR_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            counter_q      <= '0;
            active_level_q <= '0;
            tick_q         <= 1'b0;
            tick_count_q   <= '0;
        end else begin
            counter_q      <= counter_d;
            active_level_q <= active_level_d;
            tick_q         <= tick_d;
            tick_count_q   <= tick_count_d;
        end
    end

    tick_subdivider #(
        .SUBDIV (SUBDIV),
        .SUBP_W (CTR_W)
    ) u_subdivider (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (sub_clear),
        .enable    (sub_enable),
        .subp      (subp_tab[active_level_q]),
        .main_tick (tick_d),
        .sub_tick  (sub_tick),
        .sub_idx   (sub_idx)
    );

    assign tick         = tick_q;
    assign active_level = active_level_q;
    assign tick_count   = tick_count_q;

endmodule

// File: tb/tb_speed_tick_gen.sv
// Scenario tests plus a randomized run of speed_tick_gen, checked against a
// cycle-position model derived from the period arithmetic.
module tb_speed_tick_gen;

    localparam int IN_F = 100;
    localparam int BASE = 10;
    localparam int STEP = 10;
    localparam int NL   = 4;
    localparam int SD   = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  level_i = 2'd0;
    logic        pause_i = 1'b0;
    logic        step_i = 1'b0;
    logic        restart_i = 1'b0;
    logic        tick;
    logic        sub_tick;
    logic [0:0]  sub_idx;
    logic [1:0]  active_level;
    logic [15:0] tick_count;

    int vectors = 0;
    int errors = 0;

    int   m_pos = 0;
    int   m_lvl = 0;
    int   m_cnt = 0;
    int   exp_sidx = 0;
    logic exp_tick = 1'b0;
    logic exp_sub = 1'b0;

    logic [20:0] got_vec;
    logic [20:0] exp_vec;

    speed_tick_gen #(
        .INPUT_CLK_FREQ  (IN_F),
        .BASE_TICK_FREQ  (BASE),
        .LEVEL_STEP_FREQ (STEP),
        .NUM_LEVELS      (NL),
        .SUBDIV          (SD),
        .CNT_W           (16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .level_i      (level_i),
        .pause_i      (pause_i),
        .step_i       (step_i),
        .restart_i    (restart_i),
        .tick         (tick),
        .sub_tick     (sub_tick),
        .sub_idx      (sub_idx),
        .active_level (active_level),
        .tick_count   (tick_count)
    );

    always #5 clk = ~clk;

    function automatic int per(input int l);
        return IN_F / (BASE + l * STEP);
    endfunction

    function automatic int subp(input int l);
        return per(l) / SD;
    endfunction

    function automatic int clampl(input int l);
        return (l >= NL) ? NL - 1 : l;
    endfunction

    // Model state is the number of cycles elapsed in the current period.
    task automatic start_period();
        m_pos    = 0;
        m_lvl    = clampl(int'(level_i));
        m_cnt    = (m_cnt + 1) % 65536;
        exp_tick = 1'b1;
        exp_sub  = 1'b1;
        exp_sidx = 0;
    endtask

    task automatic advance();
        @(posedge clk);
        if (!resetn) begin
            m_pos = 0; m_lvl = 0; m_cnt = 0;
            exp_tick = 1'b0; exp_sub = 1'b0; exp_sidx = 0;
        end else if (restart_i) begin
            m_pos = 0; m_lvl = clampl(int'(level_i));
            exp_tick = 1'b0; exp_sub = 1'b0; exp_sidx = 0;
        end else if (pause_i) begin
            if (step_i) begin
                start_period();
            end else begin
                exp_tick = 1'b0; exp_sub = 1'b0;
            end
        end else begin
            m_pos = m_pos + 1;
            if (m_pos == per(m_lvl)) begin
                start_period();
            end else begin
                exp_tick = 1'b0;
                exp_sub  = (m_pos % subp(m_lvl) == 0) && (m_pos / subp(m_lvl) < SD);
                exp_sidx = (m_pos / subp(m_lvl) < SD - 1) ? m_pos / subp(m_lvl) : SD - 1;
            end
        end
        #1;
        got_vec = {tick, sub_tick, sub_idx, active_level, tick_count};
        exp_vec = {exp_tick, exp_sub, 1'(exp_sidx), 2'(m_lvl), 16'(m_cnt)};
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        advance();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        advance();
        advance();
        vectors++;
        if (got_vec !== 21'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", got_vec, 21'd0);
        end
        resetn = 1'b1;
    endtask

    task automatic test_base_rate();
        level_i = 2'd0;
        for (int e = 1; e <= 30; e++) begin
            advance();
            vectors++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL base_rate edge %0d: got %h expected %h", e, got_vec, exp_vec);
            end
        end
        vectors++;
        if (tick_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL base_rate_count: got %0d expected 3", tick_count);
        end
    endtask

    task automatic test_level_change();
        pulse_reset();
        level_i = 2'd0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 14) level_i = 2'd2;
            advance();
            vectors++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL level_change edge %0d: got %h expected %h", e, got_vec, exp_vec);
            end
            if (e == 20 || e == 23 || e == 26) begin
                vectors++;
                if (tick !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL level_change_tick edge %0d: got %b expected 1", e, tick);
                end
            end
        end
        vectors++;
        if (active_level !== 2'd2) begin
            errors++;
            $display("[TB] FAIL level_change_active: got %0d expected 2", active_level);
        end
    endtask

    task automatic test_clamp();
        level_i = 2'(7);
        for (int e = 1; e <= 12; e++) begin
            advance();
            vectors++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL clamp edge %0d: got %h expected %h", e, got_vec, exp_vec);
            end
        end
        vectors++;
        if (active_level !== 2'd3) begin
            errors++;
            $display("[TB] FAIL clamp_active: got %0d expected 3", active_level);
        end
    endtask

    task automatic test_pause_step();
        logic [15:0] saved;
        level_i = 2'd0;
        pulse_reset();
        for (int e = 1; e <= 7; e++) advance();
        saved = tick_count;
        pause_i = 1'b1;
        step_i  = 1'b1;
        pause_i = 1'b1;
        step_i  = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            advance();
            vectors++;
            if (got_vec !== exp_vec || tick !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pause edge %0d: got %h expected %h", e, got_vec, exp_vec);
            end
        end
        pause_i = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            advance();
            vectors++;
            if (got_vec !== exp_vec || tick !== (e == 3)) begin
                errors++;
                $display("[TB] FAIL resume edge %0d: got %h expected %h", e, got_vec, exp_vec);
            end
        end
        saved = tick_count;
        pause_i = 1'b1;
        advance();
        step_i = 1'b1;
        advance();
        step_i = 1'b0;
        vectors++;
        if (tick !== 1'b1 || tick_count !== saved + 16'd1 || got_vec !== exp_vec) begin
            errors++;
            $display("[TB] FAIL step: got %h expected %h", got_vec, exp_vec);
        end
        for (int e = 1; e <= 4; e++) begin
            advance();
            vectors++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL after_step edge %0d: got %h expected %h", e, got_vec, exp_vec);
            end
        end
        pause_i = 1'b0;
    endtask

    task automatic test_restart();
        logic [15:0] saved;
        level_i = 2'd0;
        pulse_reset();
        for (int e = 1; e <= 8; e++) advance();
        saved = tick_count;
        restart_i = 1'b1;
        advance();
        restart_i = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            advance();
            vectors++;
            if (got_vec !== exp_vec || tick !== (e == 10)) begin
                errors++;
                $display("[TB] FAIL restart edge %0d: got %h expected %h", e, got_vec, exp_vec);
            end
        end
        vectors++;
        if (tick_count !== saved + 16'd1) begin
            errors++;
            $display("[TB] FAIL restart_count: got %0d expected %0d", tick_count, saved + 16'd1);
        end
    endtask

    task automatic test_reset_mid();
        level_i = 2'd3;
        for (int e = 1; e <= 5; e++) advance();
        pulse_reset();
        vectors++;
        if (got_vec !== 21'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_state: got %h expected %h", got_vec, 21'd0);
        end
        for (int e = 1; e <= 10; e++) begin
            advance();
            vectors++;
            if (got_vec !== exp_vec || tick !== (e == 10)) begin
                errors++;
                $display("[TB] FAIL reset_mid edge %0d: got %h expected %h", e, got_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            resetn    = ($urandom_range(0, 49) != 0);
            restart_i = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) pause_i = ~pause_i;
            step_i    = ($urandom_range(0, 5) == 0);
            level_i   = 2'($urandom_range(0, 3));
            advance();
            vectors++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", i, got_vec, exp_vec);
            end
        end
        resetn = 1'b1; restart_i = 1'b0; pause_i = 1'b0; step_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_base_rate();
        test_level_change();
        test_clamp();
        test_pause_step();
        test_restart();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
